// File: rtl/lmc_pkg.sv
// lmc_pkg
// Shared definitions for the little-man-computer execute slice.
// Holds the default widths, the 2-bit opcode constants and the
// fetch/execute/advance state enumeration used by lmc_exec.
package lmc_pkg;

  // Default program-address width and instruction/data word width.
  // The word has to hold the 2-bit opcode plus a branch target, so M >= N+2.
  localparam int LMC_N_DEFAULT = 2;
  localparam int LMC_M_DEFAULT = 4;

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_BRZ = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    EXEC    = 2'd2,
    ADVANCE = 2'd3
  } lmc_state_t;

endpackage

// File: rtl/lmc_alu.sv
// lmc_alu
// Combinational add/subtract unit for lmc_exec.
// Ports:
//   a      - left operand (accumulator)
//   b      - right operand (zero-extended instruction operand)
//   sub    - 0: a + b, 1: a - b
//   result - M-bit wrapped result
//   carry  - carry out for add, borrow (b > a) for subtract
module lmc_alu #(
  parameter int M = lmc_pkg::LMC_M_DEFAULT
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         sub,
  output logic [M-1:0] result,
  output logic         carry
);

  logic [M:0] wide;

  // One extra bit catches the carry; for subtraction the same bit is set
  // exactly when the unsigned result went below zero, i.e. b > a.
  always_comb begin
    if (sub) begin
      wide = {1'b0, a} - {1'b0, b};
    end else begin
      wide = {1'b0, a} + {1'b0, b};
    end
  end

  assign result = wide[M-1:0];
  assign carry  = wide[M];

endmodule

// File: rtl/lmc_exec.sv
// lmc_exec
// Fetch/execute/advance sequencer of a tiny accumulator machine.
// Every instruction takes three cycles: FETCH latches RAM_out into ir,
// EXEC updates acc/carry, and ADVANCE carries exactly one program-counter
// pulse (step, or load for a taken BRZ).
// Ports:
//   timer555 - clock, rising edge
//   reset    - asynchronous active-high reset
//   run      - level enable, sampled at instruction boundaries
//   RAM_out  - instruction word at the current program address
//   pc_step  - one-cycle pulse: advance program counter
//   pc_load  - one-cycle pulse: load program counter from pc_data
//   pc_data  - branch target while pc_load is high, else 0
//   acc      - accumulator
//   carry    - carry/borrow of the last ADD/SUB
//   zero     - acc == 0 (combinational)
//   ir       - instruction register
//   busy     - high whenever not IDLE
module lmc_exec
  import lmc_pkg::*;
#(
  parameter int N = LMC_N_DEFAULT,
  parameter int M = LMC_M_DEFAULT
) (
  input  logic         timer555,
  input  logic         reset,
  input  logic         run,
  input  logic [M-1:0] RAM_out,
  output logic         pc_step,
  output logic         pc_load,
  output logic [N-1:0] pc_data,
  output logic [M-1:0] acc,
  output logic         carry,
  output logic         zero,
  output logic [M-1:0] ir,
  output logic         busy
);

  lmc_state_t   state_q, state_d;
  logic [M-1:0] acc_q, acc_d;
  logic         carry_q, carry_d;
  logic [M-1:0] ir_q, ir_d;
  logic         pc_step_q, pc_step_d;
  logic         pc_load_q, pc_load_d;
  logic [N-1:0] pc_data_q, pc_data_d;

  logic [1:0]   opcode;
  logic [M-1:0] operand_ext;
  logic [M-1:0] alu_result;
  logic         alu_carry;

  assign opcode      = ir_q[M-1:M-2];
  assign operand_ext = {2'b00, ir_q[M-3:0]};

  lmc_alu #(.M(M)) u_alu (
    .a      (acc_q),
    .b      (operand_ext),
    .sub    (opcode == OP_SUB),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Next-state logic. The pc pulse is decided while leaving EXEC so that the
  // registered pc_step/pc_load are high for exactly the ADVANCE cycle. BRZ
  // never changes acc, so testing acc_q here matches the acc seen in ADVANCE.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    ir_d      = ir_q;
    pc_step_d = 1'b0;
    pc_load_d = 1'b0;
    pc_data_d = '0;
    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        ir_d    = RAM_out;
        state_d = EXEC;
      end
      EXEC: begin
        case (opcode)
          OP_LDI: acc_d = operand_ext;
          OP_ADD, OP_SUB: begin
            acc_d   = alu_result;
            carry_d = alu_carry;
          end
          default: ;
        endcase
        if (opcode == OP_BRZ && acc_q == '0) begin
          pc_load_d = 1'b1;
          pc_data_d = ir_q[N-1:0];
        end else begin
          pc_step_d = 1'b1;
        end
        state_d = ADVANCE;
      end
      ADVANCE: begin
        state_d = run ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any instruction in flight.
  always_ff @(posedge timer555 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      ir_q      <= '0;
      pc_step_q <= 1'b0;
      pc_load_q <= 1'b0;
      pc_data_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      ir_q      <= ir_d;
      pc_step_q <= pc_step_d;
      pc_load_q <= pc_load_d;
      pc_data_q <= pc_data_d;
    end
  end

  assign acc     = acc_q;
  assign carry   = carry_q;
  assign zero    = (acc_q == '0);
  assign ir      = ir_q;
  assign pc_step = pc_step_q;
  assign pc_load = pc_load_q;
  assign pc_data = pc_data_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_lmc_exec.sv
// tb_lmc_exec
// Directed testbench for lmc_exec (N=2, M=4): a table of instructions
// executed back-to-back with run held high, followed by hand-written
// sequences for run dropping mid-instruction and reset during EXEC.
module tb_lmc_exec;

  logic       timer555;
  logic       reset;
  logic       run;
  logic [3:0] RAM_out;
  logic       pc_step;
  logic       pc_load;
  logic [1:0] pc_data;
  logic [3:0] acc;
  logic       carry;
  logic       zero;
  logic [3:0] ir;
  logic       busy;

  int checks;
  int failures;

  typedef struct {
    logic [3:0] instr;
    logic [3:0] exp_acc;
    logic       exp_carry;
    logic       exp_zero;
    logic       exp_step;
    logic       exp_load;
    logic [1:0] exp_data;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  lmc_exec #(.N(2), .M(4)) dut (
    .timer555 (timer555),
    .reset    (reset),
    .run      (run),
    .RAM_out  (RAM_out),
    .pc_step  (pc_step),
    .pc_load  (pc_load),
    .pc_data  (pc_data),
    .acc      (acc),
    .carry    (carry),
    .zero     (zero),
    .ir       (ir),
    .busy     (busy)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    timer555 = 1'b0;
    forever #5 timer555 = ~timer555;
  end

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge timer555);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Runs one instruction starting from a FETCH cycle, checking the quiet
  // EXEC cycle and the pulse/result in ADVANCE, and ends back in FETCH.
  task automatic applyStimulus(input int idx);
    vec_t v;
    v = vecs[idx];
    RAM_out = v.instr;
    step();
    checkOutput($sformatf("v%0d_exec_ir", idx), {4'h0, ir}, {4'h0, v.instr});
    checkOutput($sformatf("v%0d_exec_pulses", idx), {6'h0, pc_step, pc_load}, 8'h00);
    step();
    checkOutput($sformatf("v%0d_acc", idx), {4'h0, acc}, {4'h0, v.exp_acc});
    checkOutput($sformatf("v%0d_carry", idx), {7'h0, carry}, {7'h0, v.exp_carry});
    checkOutput($sformatf("v%0d_zero", idx), {7'h0, zero}, {7'h0, v.exp_zero});
    checkOutput($sformatf("v%0d_step", idx), {7'h0, pc_step}, {7'h0, v.exp_step});
    checkOutput($sformatf("v%0d_load", idx), {7'h0, pc_load}, {7'h0, v.exp_load});
    checkOutput($sformatf("v%0d_data", idx), {6'h0, pc_data}, {6'h0, v.exp_data});
    checkOutput($sformatf("v%0d_busy", idx), {7'h0, busy}, 8'h01);
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //                instr    acc    c     z     step  load  data
    vecs[0]  = '{4'b0011, 4'd3,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[1]  = '{4'b0110, 4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[2]  = '{4'b0001, 4'd1,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[3]  = '{4'b1010, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[4]  = '{4'b0101, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[5]  = '{4'b1110, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 2'd2};
    vecs[6]  = '{4'b0000, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[7]  = '{4'b0011, 4'd3,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[8]  = '{4'b0101, 4'd4,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[9]  = '{4'b1110, 4'd4,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[10] = '{4'b1011, 4'd1,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[11] = '{4'b1011, 4'd14, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[12] = '{4'b0111, 4'd1,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[13] = '{4'b0111, 4'd4,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[14] = '{4'b1111, 4'd4,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[15] = '{4'b0000, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[16] = '{4'b1101, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 2'd1};

    reset   = 1'b1;
    run     = 1'b0;
    RAM_out = 4'b0000;
    step();
    step();

    // Reset state
    checkOutput("rst_acc",   {4'h0, acc},   8'h00);
    checkOutput("rst_carry", {7'h0, carry}, 8'h00);
    checkOutput("rst_ir",    {4'h0, ir},    8'h00);
    checkOutput("rst_step",  {7'h0, pc_step}, 8'h00);
    checkOutput("rst_load",  {7'h0, pc_load}, 8'h00);
    checkOutput("rst_data",  {6'h0, pc_data}, 8'h00);
    checkOutput("rst_zero",  {7'h0, zero},  8'h01);
    checkOutput("rst_busy",  {7'h0, busy},  8'h00);

    reset = 1'b0;
    step();
    checkOutput("idle_busy", {7'h0, busy}, 8'h00);

    run = 1'b1;
    step();
    checkOutput("first_fetch_busy", {7'h0, busy}, 8'h01);
    checkOutput("first_fetch_pulses", {6'h0, pc_step, pc_load}, 8'h00);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(i);
    end

    // run dropped during EXEC: instruction completes with one pulse, then IDLE
    RAM_out = 4'b0010;
    step();
    run = 1'b0;
    step();
    checkOutput("drop_adv_step", {7'h0, pc_step}, 8'h01);
    checkOutput("drop_adv_load", {7'h0, pc_load}, 8'h00);
    checkOutput("drop_adv_acc",  {4'h0, acc},     8'h02);
    step();
    checkOutput("drop_idle_busy", {7'h0, busy},    8'h00);
    checkOutput("drop_idle_step", {7'h0, pc_step}, 8'h00);
    step();
    checkOutput("drop_idle2_busy", {7'h0, busy},    8'h00);
    checkOutput("drop_idle2_step", {7'h0, pc_step}, 8'h00);
    checkOutput("drop_idle2_acc",  {4'h0, acc},     8'h02);
    RAM_out = 4'b0101;
    run = 1'b1;
    step();
    checkOutput("rerun_fetch_busy", {7'h0, busy}, 8'h01);
    step();
    checkOutput("rerun_exec_ir", {4'h0, ir}, 8'h05);

    // Now in EXEC of ADD 1 with acc=2: reset mid-cycle aborts it
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rstx_acc",  {4'h0, acc},  8'h00);
    checkOutput("rstx_busy", {7'h0, busy}, 8'h00);
    checkOutput("rstx_zero", {7'h0, zero}, 8'h01);
    checkOutput("rstx_ir",   {4'h0, ir},   8'h00);
    step();
    checkOutput("rstx_hold_pulses", {6'h0, pc_step, pc_load}, 8'h00);
    checkOutput("rstx_hold_busy",   {7'h0, busy}, 8'h00);
    reset = 1'b0;
    step();
    checkOutput("rstx_fetch_busy",   {7'h0, busy}, 8'h01);
    checkOutput("rstx_fetch_pulses", {6'h0, pc_step, pc_load}, 8'h00);
    step();
    checkOutput("rstx_exec_ir", {4'h0, ir}, 8'h05);
    step();
    checkOutput("rstx_adv_acc",   {4'h0, acc},     8'h01);
    checkOutput("rstx_adv_carry", {7'h0, carry},   8'h00);
    checkOutput("rstx_adv_step",  {7'h0, pc_step}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lmc_exec.md
LMC_EXEC -- requirements
Module: lmc_exec

Interface
REQ-001 SHALL provide parameter N, default 2, meaning program-address width; it matches the program counter width.
REQ-002 SHALL provide parameter M, default 4, meaning instruction/data word width; M SHALL be at least N+2.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; no other clock or reset exists.
REQ-004 timer555  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 run  input  1  level; high permits fetch/execute, low parks the block in IDLE at an instruction boundary.
REQ-007 RAM_out  input  M  instruction word at the current program address, driven by the program store.
REQ-008 pc_step  output  1  one-cycle pulse; program counter advances by 1.
REQ-009 pc_load  output  1  one-cycle pulse; program counter loads pc_data.
REQ-010 pc_data  output  N  branch target, valid while pc_load is high, otherwise 0.
REQ-011 acc  output  M  accumulator.
REQ-012 carry  output  1  carry (ADD) or borrow (SUB) of the last arithmetic instruction.
REQ-013 zero  output  1  high when acc == 0.
REQ-014 ir  output  M  latched instruction register.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 Instruction format: opcode = ir[M-1:M-2], operand = ir[M-3:0]; branch target = operand[N-1:0].
REQ-017 Opcodes:
- 00 LDI: acc <= zero-extended operand; carry unchanged.
- 01 ADD: {carry,acc} <= acc + operand, M-bit wrap.
- 10 SUB: acc <= acc - operand, M-bit wrap; carry <= 1 when operand > acc.
- 11 BRZ: acc and carry unchanged.
REQ-018 FSM states SHALL be IDLE, FETCH, EXEC and ADVANCE.
REQ-019 Transitions:
- IDLE -> FETCH when run=1.
- FETCH -> EXEC.
- EXEC -> ADVANCE.
- ADVANCE -> FETCH when run=1, else IDLE.
REQ-020 FETCH: ir <= RAM_out; no other register changes.
REQ-021 EXEC: acc, carry and zero update per REQ-017 on the edge leaving EXEC.
REQ-022 ADVANCE, opcode BRZ with acc==0: pc_load=1, pc_data=target, pc_step=0.
REQ-023 ADVANCE, all other cases: pc_step=1, pc_load=0.
REQ-024 pc_step and pc_load SHALL never be high together, and SHALL only be high in ADVANCE; both are registered outputs.
REQ-025 Each instruction takes exactly 3 cycles (FETCH, EXEC, ADVANCE); with run held high, one pc_step/pc_load pulse occurs every 3 cycles.
REQ-026 When run falls mid-instruction, the current instruction SHALL complete through ADVANCE before entering IDLE.
REQ-027 Program-counter wrap (address 2**N-1 -> 0) is owned by the counter; lmc_exec only pulses pc_step.
REQ-028 zero is combinational from acc; all other outputs are registered.

Reset
REQ-029 While reset is high, the block SHALL be in state IDLE with acc=0, carry=0, ir=0, pc_step=0, pc_load=0 and pc_data=0; zero=1 and busy=0 follow from that.
REQ-030 Reset asserted mid-instruction SHALL abort the instruction with no pc pulse; the first FETCH occurs on the first edge after reset release with run=1, plus one cycle.

Structure
REQ-031 Shared package lmc_pkg SHALL hold:
- opcode constants OP_LDI, OP_ADD, OP_SUB and OP_BRZ;
- the FSM state enumeration;
- the default N and M.
REQ-032 Sub-module lmc_alu (combinational):
- inputs: a, b, sub;
- outputs: M-bit result and carry/borrow;
- exactly one instance, used in EXEC.

Verification
REQ-033 Reset, then run=1 with RAM_out=4'b0011 (LDI 3) -> acc=3, carry=0, pc_step pulse on the 3rd cycle after FETCH start.
REQ-034 acc=3, ADD 2 (4'b0110) -> acc=5, carry=0; acc=15 (M=4), ADD 1 -> acc=0, carry=1, zero=1.
REQ-035 acc=1, SUB 2 (4'b1010) -> acc=15, carry=1, zero=0.
REQ-036 acc=0, BRZ 2 (4'b1110) -> pc_load=1 with pc_data=2, pc_step=0; acc=4, BRZ 2 -> pc_step=1, pc_load=0.
REQ-037 run dropped during EXEC -> ADVANCE still pulses exactly once, then IDLE with busy=0; run raised again -> FETCH on the next edge.
REQ-038 reset asserted during EXEC of ADD -> acc=0 immediately, no pc pulse, state IDLE.
